// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - pointer and flag controller for a BRAM FIFO (2^ADDR_WIDTH x 8 dual-port RAM)
// Optional sticky Overflow/Underflow outputs are built when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int AF_LEVEL   = 28,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Wr,
  input  logic                  Rd,
  output logic                  WR_en,
  output logic [ADDR_WIDTH-1:0] Write_addr,
  output logic [ADDR_WIDTH-1:0] Read_addr,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Almost_full,
  output logic                  Almost_empty,
  output logic [ADDR_WIDTH:0]   Count
`ifdef FIFO_CTRL_ERR_EN
  ,
  output logic                  Overflow,
  output logic                  Underflow
`endif
);
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_THR = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_THR = PW'(AE_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          push, pop, full_nxt, empty_nxt;

  // Requests are gated by the registered flags, so a rejected request changes nothing.
  assign push  = Wr & ~Full;
  assign pop   = Rd & ~Empty;
  assign WR_en = push;

  assign Write_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign Read_addr  = rd_ptr[ADDR_WIDTH-1:0];

  always_comb begin
    wr_ptr_nxt = wr_ptr + PW'(push);
    rd_ptr_nxt = rd_ptr + PW'(pop);
    count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    // Same slot but different wrap bit means the writer is a full lap ahead.
    full_nxt   = (wr_ptr_nxt[PW-1] != rd_ptr_nxt[PW-1]) &&
                 (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      Count        <= '0;
      Full         <= 1'b0;
      Empty        <= 1'b1;
      Almost_full  <= 1'b0;
      Almost_empty <= 1'b1;
    end else begin
      wr_ptr       <= wr_ptr_nxt;
      rd_ptr       <= rd_ptr_nxt;
      Count        <= count_nxt;
      Full         <= full_nxt;
      Empty        <= empty_nxt;
      Almost_full  <= (count_nxt >= AF_THR);
      Almost_empty <= (count_nxt <= AE_THR);
    end
  end

`ifdef FIFO_CTRL_ERR_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (Wr && Full)  Overflow  <= 1'b1;
      if (Rd && Empty) Underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - self-checking bench for fifo_ctrl with a RAM model and data scoreboard
module tb_fifo_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr, rd;
  logic       wr_en;
  logic [4:0] write_addr, read_addr;
  logic       full, empty, almost_full, almost_empty;
  logic [5:0] count;
`ifdef FIFO_CTRL_ERR_EN
  logic       overflow, underflow;
`endif

  logic [7:0] ram [32];
  logic [7:0] wdata;
  logic [7:0] next_data;
  logic [7:0] sb [$];

  int total = 0;
  int bad   = 0;
  int mcount, mw, mr;

  typedef struct {
    logic wr;
    logic rd;
    int   reps;
    int   cnt;
    int   waddr;
    int   raddr;
    logic full;
    logic empty;
  } vec_t;
  vec_t tbl [15];

  fifo_ctrl #(.ADDR_WIDTH(5), .AF_LEVEL(28), .AE_LEVEL(4)) dut (
    .Clk          (clk),
    .Rst_n        (rst_n),
    .Wr           (wr),
    .Rd           (rd),
    .WR_en        (wr_en),
    .Write_addr   (write_addr),
    .Read_addr    (read_addr),
    .Full         (full),
    .Empty        (empty),
    .Almost_full  (almost_full),
    .Almost_empty (almost_empty),
    .Count        (count)
`ifdef FIFO_CTRL_ERR_EN
    ,
    .Overflow     (overflow),
    .Underflow    (underflow)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wr_en) ram[write_addr] <= wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state();
    chk("count", 32'(count), 32'(mcount));
    chk("full", 32'(full), 32'(mcount == 32));
    chk("empty", 32'(empty), 32'(mcount == 0));
    chk("almost_full", 32'(almost_full), 32'(mcount >= 28));
    chk("almost_empty", 32'(almost_empty), 32'(mcount <= 4));
    chk("write_addr", 32'(write_addr), 32'(mw));
    chk("read_addr", 32'(read_addr), 32'(mr));
  endtask

  task automatic step(input logic w, input logic r);
    logic exp_push, exp_pop;
    logic [7:0] exp_d;
    @(negedge clk);
    wr = w;
    rd = r;
    wdata = next_data;
    #1;
    exp_push = w && (mcount < 32);
    exp_pop  = r && (mcount > 0);
    chk("wr_en", 32'(wr_en), 32'(exp_push));
    if (exp_pop) begin
      if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(0), 32'(1));
      end else begin
        exp_d = sb.pop_front();
        chk("read_data", 32'(ram[read_addr]), 32'(exp_d));
      end
    end
    if (exp_push) begin
      sb.push_back(wdata);
      next_data = next_data + 8'd1;
    end
    @(posedge clk);
    #1;
    mcount = mcount + int'(exp_push) - int'(exp_pop);
    mw = (mw + int'(exp_push)) % 32;
    mr = (mr + int'(exp_pop)) % 32;
    chk_state();
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 32, 32,  0,  0, 1'b1, 1'b0};
    tbl[1]  = '{1'b1, 1'b0,  1, 32,  0,  0, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 32,  0,  0,  0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 1'b1,  1,  0,  0,  0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 20, 20, 20,  0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 20,  0, 20, 20, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 20, 20,  8, 20, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 10, 10,  8, 30, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1,  5, 10, 13,  3, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 10,  0, 13, 13, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1,  1,  1, 14, 13, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 31, 32, 13, 13, 1'b1, 1'b0};
    tbl[12] = '{1'b1, 1'b1,  1, 31, 13, 14, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0,  2, 31, 13, 14, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 14, 17, 13, 28, 1'b0, 1'b0};

    rst_n = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    wdata = 8'd0;
    next_data = 8'd1;
    mcount = 0;
    mw = 0;
    mr = 0;
    #12;
    chk_state();
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow_rst", 32'(overflow), 32'(0));
    chk("underflow_rst", 32'(underflow), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < tbl[i].reps; k++) step(tbl[i].wr, tbl[i].rd);
      chk($sformatf("row%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      chk($sformatf("row%0d_waddr", i), 32'(write_addr), 32'(tbl[i].waddr));
      chk($sformatf("row%0d_raddr", i), 32'(read_addr), 32'(tbl[i].raddr));
      chk($sformatf("row%0d_full", i), 32'(full), 32'(tbl[i].full));
      chk($sformatf("row%0d_empty", i), 32'(empty), 32'(tbl[i].empty));
    end

`ifdef FIFO_CTRL_ERR_EN
    chk("overflow_sticky", 32'(overflow), 32'(1));
    chk("underflow_sticky", 32'(underflow), 32'(1));
`endif

    // Asynchronous reset mid-stream at Count = 17, sampled before any clock edge.
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mcount = 0;
    mw = 0;
    mr = 0;
    sb.delete();
    chk_state();
`ifdef FIFO_CTRL_ERR_EN
    chk("overflow_async_rst", 32'(overflow), 32'(0));
    chk("underflow_async_rst", 32'(underflow), 32'(0));
`endif
    @(negedge clk);
    rst_n = 1'b1;

    step(1'b0, 1'b1);
`ifdef FIFO_CTRL_ERR_EN
    chk("underflow_after_rst", 32'(underflow), 32'(1));
`endif
    step(1'b1, 1'b0);
    chk("first_push_addr0", 32'(ram[0]), 32'(next_data - 8'd1));
    step(1'b0, 1'b1);
    chk("post_rst_empty", 32'(empty), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Pointer and flag controller for the BRAM-based FIFO. Accepts push/pop requests from the producer and consumer, drives the write enable and write/read addresses of the 32x8 dual-port RAM (`Dual_port_ram`), and reports occupancy status. Sits directly upstream of the RAM on its address/enable side; data flows straight from the producer to `Write_data` and from `Read_data` to the consumer.

## Interface

Parameters:
- `ADDR_WIDTH`, 5: RAM address width; depth = 2^ADDR_WIDTH = 32.
- `AF_LEVEL`, 28: `Almost_full` asserts when Count >= AF_LEVEL.
- `AE_LEVEL`, 4: `Almost_empty` asserts when Count <= AE_LEVEL.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Rst_n`  in  1  asynchronous, active-low reset.
- `Wr`  in  1  push request; the word is on the RAM `Write_data` in the same cycle.
- `Rd`  in  1  pop request; consumer takes `Read_data` in the same cycle.
- `WR_en`  out  1  to RAM: `Wr & ~Full`, combinational.
- `Write_addr`  out  ADDR_WIDTH  to RAM: low bits of the write pointer, registered.
- `Read_addr`  out  ADDR_WIDTH  to RAM: low bits of the read pointer, registered.
- `Full`  out  1  registered.
- `Empty`  out  1  registered.
- `Almost_full`  out  1  registered.
- `Almost_empty`  out  1  registered.
- `Count`  out  ADDR_WIDTH+1  occupancy 0..32, registered.
- `Overflow`  out  1  sticky; present only with `FIFO_CTRL_ERR_EN`.
- `Underflow`  out  1  sticky; present only with `FIFO_CTRL_ERR_EN`.

## Operation

- Internal `wr_ptr` and `rd_ptr` are ADDR_WIDTH+1 bits wide; the MSB is a wrap bit.
- Push is accepted when `Wr & ~Full`; `wr_ptr` increments.
- Pop is accepted when `Rd & ~Empty`; `rd_ptr` increments.
- Pointers wrap modulo 2^(ADDR_WIDTH+1), so address 31 is followed by address 0 with the wrap bit toggled.
- Empty: pointers are equal.
- Full: low bits are equal and wrap bits differ.
- Count = `wr_ptr - rd_ptr` (unsigned, ADDR_WIDTH+1 bits).
- Flags and Count are computed from the next-state pointers, so they are exact in the cycle after the edge.
- Simultaneous Wr and Rd:
  - Neither Full nor Empty: both are accepted; Count is unchanged; Full and Empty are unchanged.
  - Full: only the pop is accepted; `WR_en` stays 0.
  - Empty: only the push is accepted; the pop is ignored.
- A rejected push or pop changes no state.
- There is no state machine beyond the pointer registers.

## Timing

- Reset (asynchronous, during or outside operation): pointers = 0, Count = 0, Empty = 1, Full = 0, Almost_empty = 1, Almost_full = 0, `Write_addr` = `Read_addr` = 0, Overflow = Underflow = 0.
- `WR_en` follows `Wr` combinationally, gated by the registered Full. The RAM writes on the same edge at which `wr_ptr` advances.
- Write-to-read latency: a word pushed at edge N clears Empty after edge N. It is readable at `Read_addr` from cycle N+1, subject to the RAM's own read latency.
- Reset asserted mid-burst discards all contents. The first push after reset release writes to address 0.

## Configuration

- Macro: `FIFO_CTRL_ERR_EN`.
- Defined:
  - `Overflow` sets on `Wr & Full`; `Underflow` sets on `Rd & Empty`.
  - Both are sticky until `Rst_n` is asserted; registered; asserted the cycle after the offending request.
- Undefined:
  - Both ports and their logic are absent.
  - Illegal requests are silently ignored.

## Test plan

- Reset, then 32 pushes of data 1..32 with Rd = 0 -> Write_addr walks 0..31; Full = 1 after the 32nd edge; Count = 32; Almost_full first = 1 when Count reaches 28.
- From Full, one push with Rd = 0 -> `WR_en` = 0; Count stays 32. With `FIFO_CTRL_ERR_EN`, Overflow = 1 and holds.
- 32 pops after the fill -> Read_addr walks 0..31; Read_data returns 1..32 in order; Empty = 1, Count = 0; Almost_empty = 1 once Count <= 4.
- Wrap-around: push 20, pop 20, then push 20 -> Write_addr wraps from 31 to 0 at the 13th push of the second batch; Count = 20; Full = 0, Empty = 0.
- Simultaneous Wr and Rd:
  - At Count = 10 for 5 cycles -> Count stays 10; both addresses advance by 5.
  - At Empty -> Count becomes 1; Read_addr unchanged.
  - At Full -> Count becomes 31; `WR_en` = 0.
- Assert `Rst_n` low mid-stream at Count = 17 -> all outputs return to reset values immediately, without waiting for a clock edge. With `FIFO_CTRL_ERR_EN`, a subsequent Rd at Empty sets Underflow = 1.
